// File: rtl/multicycle_alu_if.sv
// multicycle_alu_if: start/busy/done request and result bus between control FSM and multicycle_alu
interface multicycle_alu_if #(
    parameter int WIDTH        = 32,
    parameter int ALUSEL_WIDTH = 3
);
    logic                    start;
    logic [ALUSEL_WIDTH-1:0] ALUSel;
    logic [WIDTH-1:0]        op_a;
    logic [WIDTH-1:0]        op_b;
    logic                    busy;
    logic                    done;
    logic [WIDTH-1:0]        result;
    logic                    zero;
    modport master (output start, ALUSel, op_a, op_b, input busy, done, result, zero);
    modport slave  (input start, ALUSel, op_a, op_b, output busy, done, result, zero);
endinterface

// File: rtl/multicycle_alu.sv
// multicycle_alu: single-cycle arithmetic/logic ops plus a 1-bit-per-cycle iterative shifter
module multicycle_alu #(
    parameter int WIDTH        = 32,
    parameter int ALUSEL_WIDTH = 3,
    parameter int SHAMT_WIDTH  = 5
) (
    input logic             clk,
    input logic             rst,
    multicycle_alu_if.slave bus
);
    localparam logic [ALUSEL_WIDTH-1:0] ADD = ALUSEL_WIDTH'(0);
    localparam logic [ALUSEL_WIDTH-1:0] SUB = ALUSEL_WIDTH'(1);
    localparam logic [ALUSEL_WIDTH-1:0] SLL = ALUSEL_WIDTH'(2);
    localparam logic [ALUSEL_WIDTH-1:0] XOR = ALUSEL_WIDTH'(3);
    localparam logic [ALUSEL_WIDTH-1:0] SRL = ALUSEL_WIDTH'(4);
    localparam logic [ALUSEL_WIDTH-1:0] SRA = ALUSEL_WIDTH'(5);
    localparam logic [ALUSEL_WIDTH-1:0] OR  = ALUSEL_WIDTH'(6);
    localparam logic [ALUSEL_WIDTH-1:0] AND = ALUSEL_WIDTH'(7);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                  r_state, w_state_n;
    logic [WIDTH-1:0]        r_work, w_work_n, r_result, w_result_n, w_alu, w_shifted;
    logic [SHAMT_WIDTH-1:0]  r_cnt, w_cnt_n, w_shamt;
    logic [ALUSEL_WIDTH-1:0] r_op, w_op_n;
    logic                    r_zero, w_zero_n, r_done, w_done_n, w_is_shift;

    assign w_shamt    = bus.op_b[SHAMT_WIDTH-1:0];
    assign w_is_shift = bus.ALUSel inside {SLL, SRL, SRA};
    assign w_shifted  = r_op == SLL ? {r_work[WIDTH-2:0], 1'b0}
                      : r_op == SRA ? {r_work[WIDTH-1], r_work[WIDTH-1:1]}
                      :               {1'b0, r_work[WIDTH-1:1]};

    // Shift ops only reach this path with shamt=0, so they pass op_a through
    always_comb begin
        case (bus.ALUSel)
            ADD:     w_alu = bus.op_a + bus.op_b;
            SUB:     w_alu = bus.op_a + ~bus.op_b + WIDTH'(1);
            XOR:     w_alu = bus.op_a ^ bus.op_b;
            OR:      w_alu = bus.op_a | bus.op_b;
            AND:     w_alu = bus.op_a & bus.op_b;
            default: w_alu = bus.op_a;
        endcase
    end

    always_comb begin
        w_state_n  = r_state;
        w_work_n   = r_work;
        w_cnt_n    = r_cnt;
        w_op_n     = r_op;
        w_result_n = r_result;
        w_zero_n   = r_zero;
        w_done_n   = 1'b0;
        if (r_state == IDLE) begin
            if (bus.start && w_is_shift && w_shamt != '0) begin
                w_state_n = SHIFT;
                w_work_n  = bus.op_a;
                w_cnt_n   = w_shamt;
                w_op_n    = bus.ALUSel;
            end else if (bus.start) begin
                w_result_n = w_alu;
                w_zero_n   = w_alu == '0;
                w_done_n   = 1'b1;
            end
        end else begin
            w_work_n = w_shifted;
            w_cnt_n  = r_cnt - SHAMT_WIDTH'(1);
            if (r_cnt == SHAMT_WIDTH'(1)) begin
                w_state_n  = IDLE;
                w_result_n = w_shifted;
                w_zero_n   = w_shifted == '0;
                w_done_n   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_work   <= '0;
            r_cnt    <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_work   <= w_work_n;
            r_cnt    <= w_cnt_n;
            r_op     <= w_op_n;
            r_result <= w_result_n;
            r_zero   <= w_zero_n;
            r_done   <= w_done_n;
        end
    end

    assign bus.busy   = r_state == SHIFT;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.zero   = r_zero;
endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: directed vectors with a queue scoreboard checked by a done-driven monitor
module tb_multicycle_alu;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    multicycle_alu_if #(.WIDTH(32), .ALUSEL_WIDTH(3)) bus ();
    multicycle_alu dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] res;
        logic        z;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && bus.done === 1'b1) begin
            if (sb.size() == 0) check("unexpected_done", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                check({e.name, "_result"}, bus.result, e.res);
                check({e.name, "_zero"}, {31'd0, bus.zero}, {31'd0, e.z});
                check({e.name, "_done_cycle"}, cyc, e.cyc);
            end
        end
    end

    task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input int n);
        bus.ALUSel = op;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.start  = 1'b1;
        sb.push_back('{res, res == 32'd0, cyc + 1 + n, name});
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, output int bc);
        bc = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                @(posedge clk);
                #1;
                return;
            end
            if (bus.busy === 1'b1) bc++;
        end
        check({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        bus.start  = 1'b0;
        bus.ALUSel = '0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_zero", {31'd0, bus.zero}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        issue("add_wrap", 3'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0);
        wait_done("add_wrap", 5, bc);
        check("add_busy_cycles", bc, 0);

        issue("sub", 3'd1, 32'd5, 32'd7, 32'hFFFFFFFE, 0);
        issue("xor", 3'd3, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0, 0);
        wait_done("xor", 5, bc);

        issue("sra4", 3'd5, 32'h80000000, 32'h00000024, 32'hF8000000, 4);
        wait_done("sra4", 20, bc);
        check("sra4_busy_cycles", bc, 4);

        issue("sll31", 3'd2, 32'h00000001, 32'd31, 32'h80000000, 31);
        wait_done("sll31", 50, bc);
        check("sll31_busy_cycles", bc, 31);

        issue("srl0", 3'd4, 32'h80000000, 32'd0, 32'h80000000, 0);
        wait_done("srl0", 5, bc);
        check("srl0_busy_cycles", bc, 0);

        issue("or", 3'd6, 32'h12340000, 32'h00005678, 32'h12345678, 0);
        wait_done("or", 5, bc);

        issue("srl10", 3'd4, 32'hFFFFFFFF, 32'd10, 32'h003FFFFF, 10);
        @(posedge clk);
        #1 bus.ALUSel = 3'd0;
        bus.op_a = 32'h1;
        bus.op_b = 32'h1;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done("srl10", 20, bc);
        check("srl10_busy_tail", bc, 5);

        bus.ALUSel = 3'd2;
        bus.op_a   = 32'h00000001;
        bus.op_b   = 32'd8;
        bus.start  = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_result", bus.result, 32'd0);
        check("abort_zero", {31'd0, bus.zero}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("abort_idle_busy", {31'd0, bus.busy}, 32'd0);

        issue("and", 3'd7, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 0);
        wait_done("and", 5, bc);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
- Sequential execution unit that consumes the 3-bit ALUSel code produced by the ALU control unit and computes the result.
- Intended for the planned multi-cycle datapath variant.
- ADD, SUB, XOR, OR and AND complete in one cycle.
- SLL, SRL and SRA use a 1-bit-per-cycle iterative shifter to save area.
- A start/busy/done handshake couples the block to the multi-cycle control FSM.

Parameters:
WIDTH  32  operand/result width; must be a power of two, >= 8
ALUSEL_WIDTH  3  width of ALUSel
SHAMT_WIDTH  5  shift-amount bits taken from op_b; equals log2(WIDTH)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
ALUSel  input  ALUSEL_WIDTH  operation code, sampled with start
op_a  input  WIDTH  operand A, sampled with start
op_b  input  WIDTH  operand B (shift amount = op_b[SHAMT_WIDTH-1:0]), sampled with start
busy  output  1  high while an iterative shift is in progress
done  output  1  one-cycle pulse; result and zero are valid in the same cycle
result  output  WIDTH  registered result, held until the next done
zero  output  1  registered (result == 0)

Behaviour:
- Encoding: ADD=0, SUB=1, SLL=2, XOR=3, SRL=4, SRA=5, OR=6, AND=7.
- Reset (async, any state): state=IDLE, busy=0, done=0, result=0, zero=1, shift counter=0, working register=0.
- States: IDLE, SHIFT.
- IDLE, start=1, op is not a shift OR shamt=0:
  - result and zero are registered at the sampling edge E0.
  - done=1 for the cycle after E0 (latency 1).
  - State stays IDLE.
  - shamt=0 returns op_a unchanged.
- IDLE, start=1, op is a shift with shamt=n>0:
  - Working register <= op_a, counter <= n, state <= SHIFT, busy=1.
- SHIFT, each edge:
  - Working register shifts by one bit. SLL: left, fill 0. SRL: right, fill 0. SRA: right, fill with the MSB.
  - Counter decrements by 1.
  - On the edge where the counter goes 1->0: result/zero load the shifted value, done=1, busy=0, state <= IDLE.
  - done therefore appears n+1 cycles after E0; busy is high for exactly n cycles.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH; no carry or overflow outputs. SUB = op_a + ~op_b + 1. Shift amounts are unsigned; op_b upper bits are ignored.
- start while busy=1: ignored; ALUSel and operands are not captured, no effect on the in-flight operation.
- start in a cycle with done=1 (busy=0): accepted. Back-to-back single-cycle ops give done on consecutive cycles.
- done is never high for two consecutive cycles for the same operation.
- result and zero change only on a done edge or on reset.
- Reset mid-shift: the operation aborts, no done is issued, and all outputs take their reset values.
- Undefined ALUSel values cannot occur (3-bit full coverage).

Test Plan:
- Reset, then ADD op_a=0xFFFFFFFF, op_b=0x00000001 -> 1 cycle later: done=1, result=0x00000000, zero=1, busy stays 0.
- SUB op_a=5, op_b=7; next cycle XOR op_a=0xF0F0F0F0, op_b=0xFFFF0000 -> consecutive done pulses with result=0xFFFFFFFE then 0x0F0FF0F0; zero=0 both.
- SRA op_a=0x80000000, op_b=0x00000024 (shamt=4) -> busy=1 for 4 cycles; done 5 cycles after start; result=0xF8000000.
- SLL op_a=0x00000001, op_b=31 -> done after 32 cycles, result=0x80000000. SRL op_a=0x80000000, op_b=0 -> done after 1 cycle, result=0x80000000.
- During an SRL by 10 of 0xFFFFFFFF, pulse start with ADD at cycles 2 and 5 -> ignored; single done after 11 cycles, result=0x003FFFFF.
- Assert rst 3 cycles into an SLL by 8 -> busy=0, done=0, result=0, zero=1 immediately and async; no later done. A fresh AND 0xFF00FF00 & 0x0FF00FF0 then gives 0x0F000F00 after 1 cycle.
